// File: rtl/lwb_pkg.sv
// rtl/lwb_pkg.sv - shared widths and index helpers for the line window buffer
package lwb_pkg;

  // Bank index width; a 2-bank ring still needs one select bit.
  function automatic int bank_idx_w(input int lines);
    return (lines > 2) ? $clog2(lines) : 1;
  endfunction

  function automatic int pix_word_w(input int pix_w, input int channels);
    return pix_w * channels;
  endfunction

  function automatic int unsigned inc_mod(input int unsigned v, input int unsigned m);
    return (v + 32'd1 >= m) ? 32'd0 : v + 32'd1;
  endfunction

  // Right-neighbour column, replicating the last active column at the edge.
  function automatic int unsigned clamp_col(input int unsigned x, input int unsigned cols);
    return (x >= cols) ? cols : x + 32'd1;
  endfunction

endpackage

// File: rtl/lwb_line_bank.sv
// rtl/lwb_line_bank.sv - one line bank: two mirrored RAMs so columns x and x1 read in parallel
module lwb_line_bank #(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr0,
  input  logic [AW-1:0] raddr1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1
);

  logic [DW-1:0] mem0 [0:(1<<AW)-1];
  logic [DW-1:0] mem1 [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem0[waddr] <= wdata;
      mem1[waddr] <= wdata;
    end
    rdata0 <= mem0[raddr0];
    rdata1 <= mem1[raddr1];
  end

endmodule

// File: rtl/line_window_buffer.sv
// rtl/line_window_buffer.sv - ring of line banks serving a registered 2x2 window
// LWB_STATUS_EN adds the sticky o_err output.
module line_window_buffer
  import lwb_pkg::*;
#(
  parameter int IMAGE_WIDTH = 11,
  parameter int PIX_W       = 8,
  parameter int CHANNELS    = 1,
  parameter int LINES       = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_frame_start,
  input  logic [IMAGE_WIDTH-1:0]       i_cols,
  input  logic                         i_wr_valid,
  input  logic [CHANNELS*PIX_W-1:0]    i_wr_data,
  output logic                         o_wr_ready,
  input  logic                         i_rd_req,
  input  logic [IMAGE_WIDTH-1:0]       i_rd_addr,
  input  logic                         i_rd_line_adv,
  output logic [$clog2(LINES+1)-1:0]   o_lines_avail,
  output logic [CHANNELS*PIX_W-1:0]    o_pix_00,
  output logic [CHANNELS*PIX_W-1:0]    o_pix_01,
  output logic [CHANNELS*PIX_W-1:0]    o_pix_10,
  output logic [CHANNELS*PIX_W-1:0]    o_pix_11,
  output logic                         o_pix_valid
`ifdef LWB_STATUS_EN
  , output logic                       o_err
`endif
);

  localparam int PW = pix_word_w(PIX_W, CHANNELS);
  localparam int BW = bank_idx_w(LINES);
  localparam int CW = $clog2(LINES+1);
  localparam logic [CW-1:0] FULL = CW'(LINES);
  localparam logic [CW-1:0] TWO  = CW'(2);

  logic [BW-1:0]          wr_bank, rd_bank, rd_bank_bot, top_s1, bot_s1;
  logic [IMAGE_WIDTH-1:0] wr_col, col1;
  logic [CW-1:0]          count;
  logic                   wr_fire, line_done, line_adv, rd_fire, v1;
  logic [PW-1:0]          rd0 [LINES];
  logic [PW-1:0]          rd1 [LINES];

  assign o_wr_ready    = (count < FULL);
  assign o_lines_avail = count;
  assign wr_fire       = i_wr_valid & o_wr_ready;
  assign line_done     = wr_fire & (wr_col == i_cols);
  assign line_adv      = i_rd_line_adv & (count != '0);
  assign rd_fire       = i_rd_req & (count >= TWO);
  assign rd_bank_bot   = BW'(inc_mod(32'(rd_bank), LINES));
  assign col1          = IMAGE_WIDTH'(clamp_col(32'(i_rd_addr), 32'(i_cols)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= '0;
      rd_bank <= '0;
      wr_col  <= '0;
      count   <= '0;
    end else if (i_frame_start) begin
      wr_bank <= '0;
      rd_bank <= '0;
      wr_col  <= '0;
      count   <= '0;
    end else begin
      if (wr_fire)   wr_col  <= line_done ? '0 : wr_col + 1'b1;
      if (line_done) wr_bank <= BW'(inc_mod(32'(wr_bank), LINES));
      if (line_adv)  rd_bank <= rd_bank_bot;
      if (line_done && !line_adv)      count <= count + 1'b1;
      else if (!line_done && line_adv) count <= count - 1'b1;
    end
  end

  // All banks see the same read columns; the bank selects travel with the request.
  for (genvar g = 0; g < LINES; g++) begin : g_bank
    lwb_line_bank #(
      .AW (IMAGE_WIDTH),
      .DW (PW)
    ) u_bank (
      .clk    (clk),
      .we     (wr_fire && (wr_bank == BW'(g))),
      .waddr  (wr_col),
      .wdata  (i_wr_data),
      .raddr0 (i_rd_addr),
      .raddr1 (col1),
      .rdata0 (rd0[g]),
      .rdata1 (rd1[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1          <= 1'b0;
      top_s1      <= '0;
      bot_s1      <= '0;
      o_pix_valid <= 1'b0;
      o_pix_00    <= '0;
      o_pix_01    <= '0;
      o_pix_10    <= '0;
      o_pix_11    <= '0;
    end else if (i_frame_start) begin
      v1          <= 1'b0;
      top_s1      <= '0;
      bot_s1      <= '0;
      o_pix_valid <= 1'b0;
      o_pix_00    <= '0;
      o_pix_01    <= '0;
      o_pix_10    <= '0;
      o_pix_11    <= '0;
    end else begin
      v1 <= rd_fire;
      if (rd_fire) begin
        top_s1 <= rd_bank;
        bot_s1 <= rd_bank_bot;
      end
      o_pix_valid <= v1;
      if (v1) begin
        o_pix_00 <= rd0[top_s1];
        o_pix_01 <= rd1[top_s1];
        o_pix_10 <= rd0[bot_s1];
        o_pix_11 <= rd1[bot_s1];
      end
    end
  end

`ifdef LWB_STATUS_EN
  logic err_ev;
  assign err_ev = (i_wr_valid & ~o_wr_ready) | (i_rd_req & (count < TWO)) |
                  (i_rd_line_adv & (count == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             o_err <= 1'b0;
    else if (i_frame_start) o_err <= 1'b0;
    else if (err_ev)        o_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_line_window_buffer.sv
// tb/tb_line_window_buffer.sv - scoreboard bench for line_window_buffer (LINES=3, 8 columns)
module tb_line_window_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_frame_start;
  logic [10:0] i_cols;
  logic        i_wr_valid;
  logic [7:0]  i_wr_data;
  logic        o_wr_ready;
  logic        i_rd_req;
  logic [10:0] i_rd_addr;
  logic        i_rd_line_adv;
  logic [1:0]  o_lines_avail;
  logic [7:0]  o_pix_00, o_pix_01, o_pix_10, o_pix_11;
  logic        o_pix_valid;
`ifdef LWB_STATUS_EN
  logic        o_err;
`endif

  line_window_buffer #(
    .IMAGE_WIDTH (11),
    .PIX_W       (8),
    .CHANNELS    (1),
    .LINES       (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_frame_start (i_frame_start),
    .i_cols        (i_cols),
    .i_wr_valid    (i_wr_valid),
    .i_wr_data     (i_wr_data),
    .o_wr_ready    (o_wr_ready),
    .i_rd_req      (i_rd_req),
    .i_rd_addr     (i_rd_addr),
    .i_rd_line_adv (i_rd_line_adv),
    .o_lines_avail (o_lines_avail),
    .o_pix_00      (o_pix_00),
    .o_pix_01      (o_pix_01),
    .o_pix_10      (o_pix_10),
    .o_pix_11      (o_pix_11),
    .o_pix_valid   (o_pix_valid)
`ifdef LWB_STATUS_EN
    , .o_err       (o_err)
`endif
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  int          m_count = 0;
  int          m_top = 0;
  logic [31:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line id k holds value k*16+col in column col.
  task automatic write_line(input int id, input bit adv_last);
    for (int c = 0; c < 8; c++) begin
      i_wr_valid = 1'b1;
      i_wr_data  = 8'(id * 16 + c);
      if (c == 7 && adv_last) i_rd_line_adv = 1'b1;
      tick();
    end
    i_wr_valid    = 1'b0;
    i_rd_line_adv = 1'b0;
    if (adv_last) m_top++;
    else          m_count++;
  endtask

  task automatic read_px(input int x);
    int x1;
    x1 = (x >= 7) ? 7 : x + 1;
    i_rd_req  = 1'b1;
    i_rd_addr = 11'(x);
    if (m_count >= 2)
      sb_q.push_back({8'(m_top * 16 + x), 8'(m_top * 16 + x1),
                      8'((m_top + 1) * 16 + x), 8'((m_top + 1) * 16 + x1)});
    tick();
    i_rd_req = 1'b0;
  endtask

  task automatic line_adv();
    i_rd_line_adv = 1'b1;
    tick();
    i_rd_line_adv = 1'b0;
    if (m_count > 0) begin
      m_count--;
      m_top++;
    end
  endtask

  task automatic frame_start();
    i_frame_start = 1'b1;
    sb_q.delete();
    tick();
    i_frame_start = 1'b0;
    m_count = 0;
  endtask

  task automatic drain();
    repeat (4) tick();
    check("drain", sb_q.size(), 0);
  endtask

  task automatic expect_idle(input int n);
    repeat (n) begin
      @(negedge clk);
      check("no_valid", o_pix_valid, 0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && o_pix_valid === 1'b1) begin
      if (sb_q.size() == 0) check("unexpected_valid", o_pix_valid, 0);
      else check("window", {o_pix_00, o_pix_01, o_pix_10, o_pix_11}, sb_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; i_frame_start = 1'b0; i_cols = 11'd7; i_wr_valid = 1'b0; i_wr_data = '0;
    i_rd_req = 1'b0; i_rd_addr = '0; i_rd_line_adv = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    check("rst_ready", o_wr_ready, 1);
    check("rst_avail", o_lines_avail, 0);
    check("rst_valid", o_pix_valid, 0);
    check("rst_pix", {o_pix_00, o_pix_01, o_pix_10, o_pix_11}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    for (int l = 0; l < 3; l++) begin
      write_line(l, 1'b0);
      check("fill_avail", o_lines_avail, m_count);
      check("fill_ready", o_wr_ready, (l < 2) ? 1 : 0);
    end
    i_wr_valid = 1'b1;
    i_wr_data  = 8'h99;
    tick();
    i_wr_valid = 1'b0;
    check("drop_avail", o_lines_avail, 3);
    check("drop_ready", o_wr_ready, 0);
`ifdef LWB_STATUS_EN
    check("err_overflow", o_err, 1);
`endif

    read_px(2);
    read_px(7);
    read_px(0);
    drain();

    line_adv();
    check("adv_avail", o_lines_avail, 2);
    write_line(3, 1'b0);
    check("wrap_avail", o_lines_avail, 3);
    read_px(0);
    drain();
    read_px(5);
    line_adv();
    read_px(0);
    drain();

    write_line(4, 1'b1);
    check("simul_avail", o_lines_avail, 2);
    check("simul_ready", o_wr_ready, 1);
    read_px(1);
    read_px(6);
    drain();

    frame_start();
    check("fs_avail", o_lines_avail, 0);
`ifdef LWB_STATUS_EN
    check("err_clear", o_err, 0);
`endif
    m_top = 5;
    write_line(5, 1'b0);
    check("under_avail", o_lines_avail, 1);
    read_px(4);
    expect_idle(3);
`ifdef LWB_STATUS_EN
    check("err_underflow", o_err, 1);
`endif
    write_line(6, 1'b0);
    read_px(3);
    frame_start();
    expect_idle(3);
    check("abort_avail", o_lines_avail, 0);
    check("abort_ready", o_wr_ready, 1);
    check("abort_queue", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/line_window_buffer.md
Name: line_window_buffer

Overview:
- Parametrised multi-line input buffer for the scaling datapath.
- Stores incoming DDR pixel lines in a ring of LINES banks.
- Serves a registered 2x2 neighbourhood (x, x+1 on lines y, y+1) to the interpolation compute unit.
- Adds over the previous 2-line ping-pong buffer: pixel width and channel count are generic; the bank ring is deeper; write backpressure and fill tracking are built in; the right-edge column is clamped; reads carry a valid strobe.

Parameters:
- IMAGE_WIDTH, 11, column address width; max line length 2^IMAGE_WIDTH.
- PIX_W, 8, bits per channel sample.
- CHANNELS, 1, channels per pixel, packed with channel 0 in the LSBs.
- LINES, 3, number of line banks in the ring; must be >= 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- i_frame_start  in  1  synchronous clear of all pointers, counters and the read pipeline
- i_cols  in  IMAGE_WIDTH  active line length minus 1; held stable during a frame
- i_wr_valid  in  1  write pixel valid
- i_wr_data  in  CHANNELS*PIX_W  write pixel
- o_wr_ready  out  1  a free bank exists
- i_rd_req  in  1  read request
- i_rd_addr  in  IMAGE_WIDTH  column x
- i_rd_line_adv  in  1  retire the oldest stored line
- o_lines_avail  out  $clog2(LINES+1)  number of complete lines stored
- o_pix_00, o_pix_01, o_pix_10, o_pix_11  out  CHANNELS*PIX_W each  (line y, x), (y, x+1), (y+1, x), (y+1, x+1)
- o_pix_valid  out  1  window outputs valid

Behaviour:
- Reset (rst_n low, asynchronous): wr_bank = rd_bank = 0, wr_col = 0, count = 0, o_pix_valid = 0, all o_pix_* = 0, o_wr_ready = 1. i_frame_start applies the same clear on the next clk edge.
- o_wr_ready = (count < LINES), combinational from registered count.
- A write is accepted when i_wr_valid & o_wr_ready. It stores to bank wr_bank at address wr_col, then wr_col increments.
- Line completion: on an accepted write with wr_col == i_cols, wr_col returns to 0, wr_bank advances by 1 modulo LINES, and count increments.
- Writes while not ready are dropped with no state change.
- Line advance: i_rd_line_adv with count > 0 advances rd_bank modulo LINES and decrements count. With count == 0 it is ignored.
- Line completion and line advance in the same cycle leave count unchanged; both bank pointers still move.
- o_lines_avail = count.
- A read is accepted when i_rd_req & (count >= 2).
  - Top row comes from rd_bank, bottom row from (rd_bank+1) mod LINES.
  - Column x+1 is clamped: x1 = (x >= i_cols) ? i_cols : x+1, which replicates the right edge.
  - Requests with count < 2 are ignored and produce no valid.
- Read latency is 2 cycles: request at cycle N gives o_pix_* and o_pix_valid = 1 at N+2. One request per cycle is sustained.
- o_pix_valid = 0 whenever no accepted read is present in stage 2. o_pix_* hold their last value while invalid.
- Reading a bank in the same cycle it is written is not supported. The ring guarantees the write bank differs from both read banks whenever count >= 2 and count < LINES.
- i_rd_line_adv issued while reads are in flight does not alter them; bank selects are pipelined with the address.
- i_frame_start mid-operation discards in-flight reads: o_pix_valid is 0 in the following 2 cycles.

Optional Feature:
- Macro LWB_STATUS_EN.
- Defined: adds output o_err (1 bit), sticky.
  - Sets on a write attempted while !o_wr_ready, a read requested while count < 2, or a line advance with count == 0.
  - Cleared by reset or i_frame_start.
- Undefined: port absent; the same events are silently ignored as described above.

Decomposition:
- Package lwb_pkg holds:
  - localparam function for bank-index width ($clog2(LINES), min 1).
  - Modulo-LINES increment function.
  - Column clamp function.
  - Pixel word width constant CHANNELS*PIX_W.
- Sub-module lwb_line_bank: one line bank.
  - Two simple-dual-port RAMs of 2^IMAGE_WIDTH x (CHANNELS*PIX_W) with a shared write port.
  - Separate read addresses x and x1, 1-cycle registered read.
  - Instantiated LINES times via generate.
- Top level holds the pointers, count, clamp, bank-select mux pipeline and output register.

Test Plan:
- Reset/fill:
  - Stimulus: i_cols = 7, LINES = 3; write 3 lines of values row*16+col.
  - Response: o_lines_avail steps 1, 2, 3; o_wr_ready drops after the 24th write; the 25th write is dropped.
- Window read:
  - Stimulus: after the fill, i_rd_req with x = 2.
  - Response: 2 cycles later o_pix_00 = 0x02, o_pix_01 = 0x03, o_pix_10 = 0x12, o_pix_11 = 0x13, o_pix_valid = 1.
- Right-edge clamp:
  - Stimulus: read x = 7.
  - Response: o_pix_00 = o_pix_01 = 0x07, o_pix_10 = o_pix_11 = 0x17.
- Ring wrap:
  - Stimulus: line advance, write line 3, read x = 0.
  - Response: o_pix_00 = 0x10, o_pix_10 = 0x20. Then advance and read again: top = 0x20, bottom = 0x30 from bank 0.
- Simultaneous completion and advance:
  - Stimulus: last write of a line in the same cycle as i_rd_line_adv at count = 2.
  - Response: count stays 2; both pointers advance.
- Underflow and abort:
  - Stimulus: read with count = 1, then i_frame_start one cycle after an accepted read.
  - Response: no o_pix_valid for either; count = 0 afterwards; o_err = 1 after the underflow read when LWB_STATUS_EN is defined.
